// File: rtl/write_grant_scheduler_pkg.sv
// rtl/write_grant_scheduler_pkg.sv - shared sizes, FSM encoding and priority unpack helper
package write_grant_scheduler_pkg;

  localparam int NUM_PORTS = 16;
  localparam int PORT_W    = 4;
  localparam int PRIO_W    = 3;
  localparam int CREDIT_W  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic logic [PRIO_W-1:0] unpack_prio(
    input logic [NUM_PORTS*PRIO_W-1:0] packed_prio,
    input int                          port
  );
    return packed_prio[port*PRIO_W +: PRIO_W];
  endfunction

endpackage

// File: rtl/write_grant_scheduler_rr_pick.sv
// rtl/write_grant_scheduler_rr_pick.sv - rotating priority encoder: first set bit at or after ptr
module write_grant_scheduler_rr_pick
  import write_grant_scheduler_pkg::*;
(
  input  logic [NUM_PORTS-1:0] vec,
  input  logic [PORT_W-1:0]    ptr,
  output logic                 found,
  output logic [PORT_W-1:0]    idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Candidate index wraps naturally through the 4-bit sum.
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && vec[ptr + PORT_W'(k)]) begin
        found = 1'b1;
        idx   = ptr + PORT_W'(k);
      end
    end
  end

endmodule

// File: rtl/write_grant_scheduler.sv
// rtl/write_grant_scheduler.sv - packet-granular SP/WRR grant of the shared SRAM write datapath
module write_grant_scheduler
  import write_grant_scheduler_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sp0_wrr1,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*PRIO_W-1:0] priority_in,
  input  logic                        done,
  output logic                        grant_valid,
  output logic [PORT_W-1:0]           grant_port,
  output logic [NUM_PORTS-1:0]        grant_onehot,
  output logic                        busy
);

  state_t               state;
  logic [CREDIT_W-1:0]  credit [NUM_PORTS];
  logic [PORT_W-1:0]    rr_ptr;

  logic [PRIO_W-1:0]    prio [NUM_PORTS];
  logic [PRIO_W-1:0]    max_prio;
  logic [NUM_PORTS-1:0] max_mask;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] wrr_vec;
  logic                 reload;
  logic [CREDIT_W-1:0]  credit_base [NUM_PORTS];
  logic [CREDIT_W-1:0]  win_credit;

  logic                 sp_found, wrr_found, arb_go;
  logic [PORT_W-1:0]    sp_idx, wrr_idx, win_idx;

  always_comb begin
    max_prio = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      prio[i] = unpack_prio(priority_in, i);
      if (req[i] && (prio[i] > max_prio)) max_prio = prio[i];
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      max_mask[i] = req[i] && (prio[i] == max_prio);
      eligible[i] = req[i] && (credit[i] != '0);
    end
  end

  // An exhausted round reloads every weight in the same cycle it is arbitrated.
  always_comb begin
    reload  = (eligible == '0);
    wrr_vec = reload ? req : eligible;
    for (int i = 0; i < NUM_PORTS; i++) begin
      credit_base[i] = reload ? (CREDIT_W'(prio[i]) + CREDIT_W'(1)) : credit[i];
    end
  end

  write_grant_scheduler_rr_pick u_sp_pick (
    .vec   (max_mask),
    .ptr   ('0),
    .found (sp_found),
    .idx   (sp_idx)
  );

  write_grant_scheduler_rr_pick u_wrr_pick (
    .vec   (wrr_vec),
    .ptr   (rr_ptr),
    .found (wrr_found),
    .idx   (wrr_idx)
  );

  assign win_credit = credit_base[wrr_idx] - CREDIT_W'(1);
  assign arb_go     = sp0_wrr1 ? wrr_found : sp_found;
  assign win_idx    = sp0_wrr1 ? wrr_idx : sp_idx;
  assign busy       = grant_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      grant_valid  <= 1'b0;
      grant_port   <= '0;
      grant_onehot <= '0;
      rr_ptr       <= '0;
      for (int i = 0; i < NUM_PORTS; i++) credit[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_go) begin
            state        <= ST_HOLD;
            grant_valid  <= 1'b1;
            grant_port   <= win_idx;
            grant_onehot <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << win_idx;
            if (sp0_wrr1) begin
              for (int i = 0; i < NUM_PORTS; i++) credit[i] <= credit_base[i];
              credit[wrr_idx] <= win_credit;
              rr_ptr <= (win_credit != '0) ? wrr_idx : (wrr_idx + PORT_W'(1));
            end
          end
        end
        ST_HOLD: begin
          if (done) begin
            state        <= ST_IDLE;
            grant_valid  <= 1'b0;
            grant_onehot <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_grant_scheduler.sv
// tb/tb_write_grant_scheduler.sv - directed and randomized checks against a behavioural arbiter model
module tb_write_grant_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        sp0_wrr1;
  logic [15:0] req;
  logic [47:0] priority_in;
  logic        done;
  logic        grant_valid;
  logic [3:0]  grant_port;
  logic [15:0] grant_onehot;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int m_credit [16];
  int m_ptr;

  always #5 clk = ~clk;

  write_grant_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .sp0_wrr1     (sp0_wrr1),
    .req          (req),
    .priority_in  (priority_in),
    .done         (done),
    .grant_valid  (grant_valid),
    .grant_port   (grant_port),
    .grant_onehot (grant_onehot),
    .busy         (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_credit[i] = 0;
    m_ptr = 0;
  endtask

  function automatic logic [47:0] setp(input logic [47:0] base, input int port, input int val);
    logic [47:0] v;
    v = base;
    v[3*port +: 3] = val[2:0];
    return v;
  endfunction

  // Reference arbitration straight from the rules: SP scans levels high to low,
  // WRR scans ports circularly from the pointer over credited requesters.
  task automatic model_arb(input logic [15:0] r, input logic [47:0] p, input bit m, output int w);
    int any;
    int idx;
    w = -1;
    if (!m) begin
      for (int lvl = 7; lvl >= 0; lvl--)
        for (int i = 0; i < 16; i++)
          if (w < 0 && r[i] && int'(p[3*i +: 3]) == lvl) w = i;
    end else begin
      any = 0;
      for (int i = 0; i < 16; i++) if (r[i] && m_credit[i] > 0) any = 1;
      if (any == 0)
        for (int i = 0; i < 16; i++) m_credit[i] = int'(p[3*i +: 3]) + 1;
      for (int k = 0; k < 16; k++) begin
        idx = (m_ptr + k) % 16;
        if (w < 0 && r[idx] && m_credit[idx] > 0) w = idx;
      end
      m_credit[w] = m_credit[w] - 1;
      m_ptr = (m_credit[w] > 0) ? w : (w + 1) % 16;
    end
  endtask

  task automatic do_grant(input logic [15:0] r, input logic [47:0] p, input bit m,
                          input int hold, input int fixed, input bit done_at_arb, input string tag);
    int w;
    logic [15:0] oh;
    req = r;
    priority_in = p;
    sp0_wrr1 = m;
    done = done_at_arb;
    model_arb(r, p, m, w);
    oh = 16'(1) << w;
    step();
    done = 1'b0;
    check({tag, ":valid"}, 32'(grant_valid), 32'd1);
    check({tag, ":port"}, 32'(grant_port), 32'(w));
    if (fixed >= 0) check({tag, ":port_spec"}, 32'(grant_port), 32'(fixed));
    check({tag, ":onehot"}, 32'(grant_onehot), 32'(oh));
    check({tag, ":busy"}, 32'(busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      req = (h == 0) ? 16'h0000 : 16'($urandom);
      priority_in[31:0] = $urandom;
      priority_in[47:32] = 16'($urandom);
      sp0_wrr1 = 1'($urandom);
      step();
      check({tag, ":hold_valid"}, 32'(grant_valid), 32'd1);
      check({tag, ":hold_port"}, 32'(grant_port), 32'(w));
      check({tag, ":hold_onehot"}, 32'(grant_onehot), 32'(oh));
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req = '0;
    check({tag, ":rel_valid"}, 32'(grant_valid), 32'd0);
    check({tag, ":rel_onehot"}, 32'(grant_onehot), 32'd0);
    check({tag, ":rel_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int seq4 [8];
    int seq5 [4];
    int w;
    logic [47:0] p;
    logic [15:0] rr;
    seq4 = '{0, 0, 0, 1, 0, 0, 0, 1};
    seq5 = '{0, 15, 0, 15};

    rst = 1'b0;
    req = 16'hFFFF;
    priority_in = '0;
    sp0_wrr1 = 1'b0;
    done = 1'b0;
    model_reset();
    step();
    step();
    check("rst:valid", 32'(grant_valid), 32'd0);
    check("rst:port", 32'(grant_port), 32'd0);
    check("rst:onehot", 32'(grant_onehot), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    rst = 1'b1;
    do_grant(16'h0010, '0, 1'b0, 1, 4, 1'b0, "rst_release");

    p = setp('0, 0, 3);
    p = setp(p, 2, 6);
    p = setp(p, 5, 6);
    do_grant(16'h0025, p, 1'b0, 5, 2, 1'b0, "sp_basic");
    do_grant(16'h0300, '0, 1'b0, 1, 8, 1'b0, "sp_zero_prio");

    done = 1'b1;
    req = '0;
    step();
    done = 1'b0;
    check("idle_done:valid", 32'(grant_valid), 32'd0);
    check("idle_done:onehot", 32'(grant_onehot), 32'd0);
    do_grant(16'h0100, '0, 1'b0, 1, 8, 1'b1, "idle_done_arb");

    p = setp('0, 0, 2);
    for (int n = 0; n < 8; n++) do_grant(16'h0003, p, 1'b1, 1, seq4[n], 1'b0, "wrr_weight");
    for (int n = 0; n < 3; n++) do_grant(16'h0003, p, 1'b1, 1, 0, 1'b0, "wrr_advance");

    req = 16'h0003;
    priority_in = p;
    sp0_wrr1 = 1'b1;
    model_arb(16'h0003, p, 1'b1, w);
    step();
    check("mid_rst:pre_port", 32'(grant_port), 32'd1);
    check("mid_rst:pre_model", 32'(grant_port), 32'(w));
    rst = 1'b0;
    step();
    check("mid_rst:valid", 32'(grant_valid), 32'd0);
    check("mid_rst:onehot", 32'(grant_onehot), 32'd0);
    check("mid_rst:port", 32'(grant_port), 32'd0);
    rst = 1'b1;
    model_reset();
    do_grant(16'h0003, p, 1'b1, 1, 0, 1'b0, "post_rst_wrr");

    pulse_reset();
    for (int n = 0; n < 4; n++) do_grant(16'h8001, '0, 1'b1, 1, seq5[n], 1'b0, "wrr_wrap");

    for (int n = 0; n < 40; n++) begin
      rr = 16'($urandom_range(1, 65535));
      p[31:0] = $urandom;
      p[47:32] = 16'($urandom);
      do_grant(rr, p, 1'($urandom), $urandom_range(0, 3), -1, 1'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/write_grant_scheduler.md
Name: write_grant_scheduler

Overview:
Sequences ownership of the shared SRAM write datapath among 16 input ports, one packet at a time. Each arbitration picks a winner by strict priority (SP) or by weighted round-robin (WRR) with per-port credit counters, registers it, and holds the grant until the datapath signals end of packet. Sits between the per-port write request logic and the SRAM write datapath/address allocator. Supplies the WRR mode that SP-only selection lacks.

Parameters:
NUM_PORTS, 16, number of requesting ports (PORT_W = 4 derived; only 16 supported).
PRIO_W, 3, per-port priority width; WRR weight = priority + 1 (range 1..8).

Ports:
clk  in  1  single clock; all logic on posedge.
rst  in  1  synchronous, active-low reset.
sp0_wrr1  in  1  0 = strict priority, 1 = weighted round-robin; sampled only at arbitration.
req  in  NUM_PORTS  per-port "packet pending" (sop level), bit i = port i.
priority_in  in  NUM_PORTS*PRIO_W  packed priorities, port i at [3i+2:3i]; sampled only at arbitration.
done  in  1  one-cycle pulse from datapath: granted packet fully written.
grant_valid  out  1  grant held.
grant_port  out  4  index of granted port.
grant_onehot  out  NUM_PORTS  one-hot of grant_port when grant_valid, else 0.
busy  out  1  equals grant_valid (kept for datapath compatibility).

Behaviour:
- Reset (rst==0 at posedge): state IDLE, grant_valid=0, grant_port=0, grant_onehot=0, busy=0, all credits=0, rr_ptr=0. Mid-HOLD reset aborts the grant at the same edge; no done is needed.
- FSM with two states, IDLE and HOLD.
- IDLE: if |req, arbitrate, register the winner, go to HOLD, grant_valid=1. Latency: req seen at edge N gives grant at N+1 output. If req==0, stay in IDLE.
- HOLD: outputs frozen; changes on req, priority_in and sp0_wrr1 are ignored. done==1 gives grant_valid=0 and a return to IDLE. This forces at least one idle cycle between grants.
- done while in IDLE: ignored.
- SP pick: highest priority among req bits. Ties, including all-zero priorities, go to the lowest index. Credits and rr_ptr are untouched in SP mode.
- WRR pick:
  - eligible = req & (credit != 0).
  - If eligible==0, reload credit[i] = priority[i]+1 for all i in the same cycle and set eligible = req.
  - Winner = first eligible index at or after rr_ptr, wrapping 15 to 0.
  - credit[winner] decrements by 1, from the reloaded value if a reload occurred.
  - New rr_ptr = winner if the post-decrement credit is non-zero, else (winner+1) mod 16. Wrap is 4-bit natural overflow.
- Credits are 4-bit unsigned and never underflow: only non-zero credits are decremented.
- Mode switch: takes effect at the next arbitration. Credits persist across SP periods.

Decomposition:
- Shared package: NUM_PORTS, PORT_W, PRIO_W, CREDIT_W=4, FSM state encodings (ST_IDLE, ST_HOLD), priority unpack function.
- One sub-module: rr_pick, a combinational rotating priority encoder with inputs vec[15:0] and ptr[3:0], and outputs found and idx[3:0]. It is reused for the SP tie-break with ptr=0 over the max-priority mask.
- Top holds the FSM, credits, rr_ptr and grant registers.

Test Plan:
1. Reset: rst=0 for 2 cycles with req=0xFFFF -> grant_valid=0, grant_port=0, grant_onehot=0. Raise rst with req=0x0010 -> grant_port=4 one cycle later.
2. SP: sp0_wrr1=0, req=0x0025, prio p0=3, p2=6, p5=6 -> grant_port=2, onehot=0x0004. Held across 5 cycles with req changing; done pulse -> grant_valid=0 the next cycle.
3. SP all-zero priorities: req=0x0300 -> grant_port=8.
4. WRR weights: sp0_wrr1=1, req=0x0003 held, p0=2, p1=0, done pulsed 2 cycles after each grant -> grant sequence 0,0,0,1,0,0,0,1.
5. WRR wrap: req=0x8001, all prio 0 -> grant sequence 0,15,0,15. rr_ptr wraps 15 to 0 correctly.
6. Boundaries:
   - done in IDLE -> no effect.
   - req dropped during HOLD -> grant stays until done.
   - rst low mid-HOLD -> grant_valid=0 next edge; credits restart, so the first WRR grant after reset with req=0x0003 goes to port 0.
